// File: rtl/count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : count_bcd_display
// Brief    : Snapshots an 8-bit count, converts it to BCD by double-dabble and
//            drives a multiplexed 3-digit seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module count_bcd_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [0:7] count_in,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       bcd_valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [2:0] an
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                 c_CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [c_CNT_W-1:0] c_REF_LAST = c_CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]         c_SEG_ZERO = 7'b1111110;
  localparam logic [6:0]         c_SEG_RST  = COMMON_ANODE ? ~c_SEG_ZERO : c_SEG_ZERO;
  localparam logic [2:0]         c_AN_RST   = COMMON_ANODE ? 3'b110 : 3'b001;

  state_t             r_state;
  state_t             w_next_state;
  logic [7:0]         w_count;
  logic [7:0]         r_last_val;
  logic               w_mismatch;
  logic [19:0]        r_shift;
  logic [19:0]        w_adj;
  logic [2:0]         r_step;
  logic [c_CNT_W-1:0] r_ref_cnt;
  logic [1:0]         r_dig_idx;
  logic [3:0]         w_digit;
  logic               w_blank;
  logic [6:0]         w_pat;
  logic [6:0]         w_seg_ah;
  logic [2:0]         w_an_ah;

  // count_in is [0:7] with bit 0 as MSB; a plain vector copy keeps numeric order.
  assign w_count    = count_in;
  assign w_mismatch = (w_count != r_last_val);

  assign w_adj[7:0] = r_shift[7:0];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
      assign w_adj[8+4*gi +: 4] = (r_shift[8+4*gi +: 4] >= 4'd5) ?
                                  (r_shift[8+4*gi +: 4] + 4'd3) : r_shift[8+4*gi +: 4];
    end
  endgenerate

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_mismatch) w_next_state = S_CONV;
      S_CONV:  if (r_step == 3'd7) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      busy    <= (w_next_state != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_last_val <= 8'd0;
      r_shift    <= 20'd0;
      r_step     <= 3'd0;
      hundreds   <= 4'd0;
      tens       <= 4'd0;
      ones       <= 4'd0;
      bcd_valid  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mismatch) begin
            r_last_val <= w_count;
            r_shift    <= {12'd0, w_count};
            r_step     <= 3'd0;
          end
        end
        S_CONV: begin
          r_shift <= {w_adj[18:0], 1'b0};
          r_step  <= r_step + 3'd1;
        end
        S_DONE: begin
          hundreds  <= r_shift[19:16];
          tens      <= r_shift[15:12];
          ones      <= r_shift[11:8];
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ref_cnt <= '0;
      r_dig_idx <= 2'd0;
    end else if (r_ref_cnt == c_REF_LAST) begin
      r_ref_cnt <= '0;
      r_dig_idx <= (r_dig_idx == 2'd2) ? 2'd0 : r_dig_idx + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  // Leading-zero blanking: ones always shown, tens hidden only under a zero hundreds.
  always_comb begin
    w_digit = ones;
    w_blank = 1'b0;
    w_an_ah = 3'b001;
    case (r_dig_idx)
      2'd1: begin
        w_digit = tens;
        w_blank = (hundreds == 4'd0) && (tens == 4'd0);
        w_an_ah = 3'b010;
      end
      2'd2: begin
        w_digit = hundreds;
        w_blank = (hundreds == 4'd0);
        w_an_ah = 3'b100;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_pat = 7'b0000000;
    case (w_digit)
      4'd0:    w_pat = 7'b1111110;
      4'd1:    w_pat = 7'b0110000;
      4'd2:    w_pat = 7'b1101101;
      4'd3:    w_pat = 7'b1111001;
      4'd4:    w_pat = 7'b0110011;
      4'd5:    w_pat = 7'b1011011;
      4'd6:    w_pat = 7'b1011111;
      4'd7:    w_pat = 7'b1110000;
      4'd8:    w_pat = 7'b1111111;
      4'd9:    w_pat = 7'b1111011;
      default: w_pat = 7'b0000000;
    endcase
  end

  assign w_seg_ah = w_blank ? 7'b0000000 : w_pat;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg <= c_SEG_RST;
      an  <= c_AN_RST;
    end else begin
      seg <= COMMON_ANODE ? ~w_seg_ah : w_seg_ah;
      an  <= COMMON_ANODE ? ~w_an_ah  : w_an_ah;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_bcd_display
// Brief    : Scoreboard bench for count_bcd_display against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_bcd_display;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [0:7] count_in = '0;
  logic [3:0] hundreds, tens, ones;
  logic       bcd_valid, busy;
  logic [6:0] seg;
  logic [2:0] an;

  count_bcd_display #(.REFRESH_DIV(RD), .COMMON_ANODE(1'b1)) dut (
    .clk(clk), .clr_n(clr_n), .count_in(count_in),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .bcd_valid(bcd_valid), .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int h; int t; int o; int v; } exp_t;
  exp_t sb_q[$];

  // Reference model: countdown timing plus decimal arithmetic for the digits.
  int         m_last = 0, m_left = 0, m_val = 0, m_edges = 0;
  int         m_h = 0, m_t = 0, m_o = 0;
  logic       m_busy = 1'b0, m_valid = 1'b0;
  logic [2:0] m_an = 3'b110;
  logic [6:0] m_seg = 7'b0000001;

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;
      2: return 7'b1101101;  3: return 7'b1111001;
      4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;
      8: return 7'b1111111;  9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int dig, input int h, input int t, input int o);
    logic [6:0] p;
    case (dig)
      1:       p = (h == 0 && t == 0) ? 7'b0000000 : seg_pat(t);
      2:       p = (h == 0) ? 7'b0000000 : seg_pat(h);
      default: p = seg_pat(o);
    endcase
    return ~p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_last = 0; m_left = 0; m_val = 0; m_edges = 0;
      m_h = 0; m_t = 0; m_o = 0;
      m_busy = 1'b0; m_valid = 1'b0;
      m_an = 3'b110; m_seg = ~seg_pat(0);
      sb_q.delete();
    end else begin
      int dig;
      dig     = (m_edges / RD) % 3;
      m_an    = ~(3'b001 << dig);
      m_seg   = exp_seg(dig, m_h, m_t, m_o);
      m_edges++;
      m_valid = 1'b0;
      if (m_left == 0) begin
        if (int'(count_in) != m_last) begin
          m_last = int'(count_in);
          m_val  = m_last;
          m_left = 9;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_h = m_val / 100;
          m_t = (m_val / 10) % 10;
          m_o = m_val % 10;
          m_valid = 1'b1;
          sb_q.push_back('{m_h, m_t, m_o, m_val});
        end
      end
      m_busy = (m_left != 0);
    end
  end

  // Monitor: per-cycle output comparison and scoreboard pop on bcd_valid.
  always @(negedge clk) begin
    exp_t e;
    check("busy", int'(busy), int'(m_busy));
    check("bcd_valid", int'(bcd_valid), int'(m_valid));
    check("an", int'(an), int'(m_an));
    check("seg", int'(seg), int'(m_seg));
    check("disp_digits", {20'd0, hundreds, tens, ones}, (m_h << 8) | (m_t << 4) | m_o);
    if (bcd_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_hundreds", int'(hundreds), e.h);
        check("sb_tens", int'(tens), e.t);
        check("sb_ones", int'(ones), e.o);
      end
    end
  end

  task automatic set_val(input int v);
    @(negedge clk);
    count_in = 8'(v);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with zero input
    clr_n    = 1'b0;
    count_in = 8'd0;
    wait_cyc(3);
    #1;
    check("rst_an", int'(an), 3'b110);
    check("rst_seg", int'(seg), 7'b0000001);
    check("rst_busy", int'(busy), 0);
    clr_n = 1'b1;
    wait_cyc(20);

    // Full scale
    set_val(255);
    wait_cyc(12);
    check("fs_digits", {20'd0, hundreds, tens, ones}, 12'h255);

    // Blanking
    set_val(7);
    wait_cyc(40);
    check("b7_digits", {20'd0, hundreds, tens, ones}, 12'h007);
    set_val(100);
    wait_cyc(40);

    // Mid-conversion change
    set_val(37);
    wait_cyc(3);
    count_in = 8'd200;
    wait_cyc(30);
    check("mid_digits", {20'd0, hundreds, tens, ones}, 12'h200);

    // Wrap and repeated value
    set_val(255);
    wait_cyc(12);
    set_val(0);
    wait_cyc(12);
    check("wrap_digits", {20'd0, hundreds, tens, ones}, 12'h000);
    set_val(0);
    wait_cyc(12);

    // Reset mid-conversion
    set_val(150);
    repeat (5) @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(bcd_valid), 0);
    check("arst_an", int'(an), 3'b110);
    check("arst_seg", int'(seg), 7'b0000001);
    check("arst_digits", {20'd0, hundreds, tens, ones}, 0);
    count_in = 8'd42;
    @(negedge clk);
    clr_n = 1'b1;
    wait_cyc(1);
    check("arst_capture_busy", int'(busy), 1);
    wait_cyc(14);
    check("arst_digits42", {20'd0, hundreds, tens, ones}, 12'h042);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) != 0) set_val(int'($urandom_range(0, 255)));
      else @(negedge clk);
      wait_cyc(int'($urandom_range(1, 14)));
    end

    wait_cyc(20);
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_bcd_display.md
# count_bcd_display

- Downstream consumer of the 8-bit up/down counter's `count` output.
- Snapshots the count value and converts it to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.
- Sits between the counter and the board display pins; has no handshake back to the counter.

## Interface

**Parameters**

- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected (must be ≥ 2).
- `COMMON_ANODE`, default 1: 1 = `seg` and `an` active-low; 0 = both active-high.

**Ports**

- `clk`  in  1  rising-edge clock; the block's single clock.
- `clr_n`  in  1  reset: asynchronous, active-low. Asserting it clears all state immediately.
- `count_in`  in  8  counter value. Bit 0 is the MSB, matching the counter's `[0:7]` ordering.
- `hundreds`  out  4  registered BCD hundreds digit (0–2).
- `tens`  out  4  registered BCD tens digit.
- `ones`  out  4  registered BCD ones digit.
- `bcd_valid`  out  1  one-cycle pulse when `hundreds`/`tens`/`ones` are updated.
- `busy`  out  1  high while a conversion is in progress.
- `seg`  out  7  segments; `seg[6]`=a … `seg[0]`=g.
- `an`  out  3  digit enables, one-hot; `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds.

## Operation

**Registers**

- `last_val[7:0]`: last captured count value.
- `shift[19:0]`: `{bcd[11:0], bin[7:0]}` working register.
- `step[2:0]`: shift-step counter.
- `state`: conversion FSM state.
- Display registers: `hundreds`, `tens`, `ones`.
- Refresh counter and `dig_idx[1:0]` (digit index).

**FSM states:** IDLE, CONV, DONE.

- **IDLE**
  - If `count_in != last_val`: load `last_val <= count_in`, `shift <= {12'b0, count_in}`, `step <= 0`, go to CONV.
  - Otherwise stay in IDLE.
- **CONV**, one shift per cycle:
  - Every BCD nibble of `shift[19:8]` that is ≥ 5 gets +3.
  - Then the whole register shifts left by 1.
  - `step` increments; after the 8th shift (`step == 7`), go to DONE.
- **DONE**
  - Copy `shift[19:16]`, `[15:12]`, `[11:8]` into `hundreds`, `tens`, `ones`.
  - Pulse `bcd_valid`; return to IDLE.
- `count_in` is ignored outside IDLE. A change made during CONV/DONE is picked up by the mismatch check on the first IDLE cycle.
- `busy` = (state != IDLE), registered with the state.

**Display multiplexing**

- The refresh counter counts 0 … `REFRESH_DIV`-1.
- At the terminal count it wraps to 0 and `dig_idx` advances 0→1→2→0.
- `an` and `seg` are registered, recomputed every cycle from `dig_idx` and the display registers.

**Blanking rules**

- Hundreds is blanked (all segments off) when `hundreds == 0`.
- Tens is blanked when `hundreds == 0` and `tens == 0`.
- Ones is never blanked.

**Segment encodings** (active-high `abcdefg`):

- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Non-BCD codes display blank.
- `COMMON_ANODE=1` inverts both `seg` and `an`.

## Timing

**Reset values** (`clr_n` low):

- `state` = IDLE, `last_val` = 0, `shift` = 0, `step` = 0.
- `hundreds` = `tens` = `ones` = 0, `bcd_valid` = 0, `busy` = 0.
- Refresh counter = 0, `dig_idx` = 0.
- With `COMMON_ANODE=1`: `an` = 3'b110, `seg` = 7'b0000001 (shows "0").

**Conversion latency**

- The mismatch is sampled at edge E0; `busy` rises after E0.
- The 8 shifts occur at edges E1–E8.
- DONE executes at E9: digits update and `bcd_valid` is high for exactly the cycle after E9; `busy` falls after E9.
- Earliest next capture is at E10, giving a maximum update rate of one conversion per 10 cycles.

**Boundary conditions**

- Counter wrap 255→0 is an ordinary mismatch; the result is 0,0,0.
- Identical consecutive values trigger no conversion and no `bcd_valid`.
- `clr_n` asserted mid-conversion aborts it.
  - All outputs go to their reset values immediately.
  - After release, a nonzero `count_in` is captured on the first edge.
- `seg`/`an` lag any change of `dig_idx` or the display registers by one cycle.
- Digit changes on `bcd_valid` take effect on the currently selected digit without waiting for the refresh counter.

## Test plan

1. **Reset with zero input.** Hold `clr_n` low, `count_in`=0, then release and run 20 cycles → digits 0,0,0; `busy` stays 0; no `bcd_valid`; `an`=110, `seg`=0000001.
2. **Full-scale value.** `count_in`=255 after reset → `busy` rises one cycle after the capture edge; `bcd_valid` pulses once, 9 edges after capture; digits 2,5,5.
3. **Blanking.**
   - `count_in`=7 → digits 0,0,7. Hundreds and tens are blank (`seg`=1111111 while `an`=011/101); ones shows 0001111.
   - `count_in`=100 → tens shows "0", not blank.
4. **Mid-conversion change.** `count_in`=37, then 200 three cycles after capture → first `bcd_valid` gives 0,3,7. Second conversion starts the cycle after; second `bcd_valid` gives 2,0,0.
5. **Refresh sequence.** `REFRESH_DIV`=4 → `an` cycles 110→101→011→110, each held exactly 4 cycles.
6. **Reset mid-conversion.** Drop `clr_n` at shift 4 of a 150 conversion → outputs reset asynchronously, no `bcd_valid`. Release with `count_in`=42 → result 0,4,2.
